scoreboard_unit: RTL and testbench

SCOREBOARD_UNIT -- requirements
Module: scoreboard_unit

---
 rtl/common_types_pkg.sv | 13 +
 rtl/scoreboard_unit_if.sv | 31 +++
 rtl/scoreboard_unit.sv | 98 +++++++++
 tb/tb_scoreboard_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared scalar types for the pipeline control blocks.
package common_types_pkg;

    // Architectural register index (32 integer registers).
    typedef logic [4:0]  regbits_t;

    // Native machine word.
    typedef logic [31:0] word_t;

    // Number of architectural registers tracked by the scoreboard.
    localparam int unsigned NUM_REGS = 32;

endpackage : common_types_pkg

// File: rtl/scoreboard_unit_if.sv
// Issue / writeback / hazard signal bundle between the ID stage and the scoreboard.
interface scoreboard_unit_if;
    import common_types_pkg::*;

    regbits_t id_rsel1;
    regbits_t id_rsel2;
    logic     issue_valid;
    logic     issue_long;
    regbits_t issue_rd;
    logic     flush;
    logic     wb_valid;
    regbits_t wb_rd;
    logic     stall;
    word_t    busy_vec;
    word_t    stall_count;

    // Pipeline side: presents instructions and retirements, observes hazards.
    modport master (
        output id_rsel1, id_rsel2, issue_valid, issue_long, issue_rd, flush,
        output wb_valid, wb_rd,
        input  stall, busy_vec, stall_count
    );

    // Scoreboard side.
    modport slave (
        input  id_rsel1, id_rsel2, issue_valid, issue_long, issue_rd, flush,
        input  wb_valid, wb_rd,
        output stall, busy_vec, stall_count
    );

endinterface : scoreboard_unit_if

// File: rtl/scoreboard_unit.sv
// Register scoreboard: tracks pending long-op writes per register, raises the
// RAW/WAW stall for the ID stage and counts stalled cycles (saturating).
module scoreboard_unit
    import common_types_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    scoreboard_unit_if.slave    sb
);

    localparam word_t COUNT_MAX = 32'hFFFF_FFFF;
    localparam word_t REG0_MASK = 32'hFFFF_FFFE;

    word_t busy_r;
    word_t stall_count_r;

    word_t wb_mask_s;
    word_t eff_busy_s;
    word_t set_mask_s;
    word_t clr_mask_s;
    word_t busy_next_s;
    word_t stall_count_next_s;
    logic  stall_s;
    logic  accept_s;

    // One-hot of the register retiring this cycle (used for the bypass view).
    always_comb begin
        wb_mask_s = 32'd0;
        if (sb.wb_valid) begin
            wb_mask_s[sb.wb_rd] = 1'b1;
        end else begin
            wb_mask_s = 32'd0;
        end
    end

    // Busy view seen by the hazard check: a same-cycle writeback is forwarded.
    assign eff_busy_s = busy_r & ~wb_mask_s;

    // RAW on either source, WAW on the destination of a long op.
    always_comb begin
        stall_s = 1'b0;
        if (sb.issue_valid && !sb.flush) begin
            stall_s = eff_busy_s[sb.id_rsel1]
                    | eff_busy_s[sb.id_rsel2]
                    | (sb.issue_long & eff_busy_s[sb.issue_rd]);
        end else begin
            stall_s = 1'b0;
        end
    end

    assign accept_s = sb.issue_valid & ~sb.flush & ~stall_s;

    // Set/clear masks; register 0 never participates.
    always_comb begin
        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (accept_s && sb.issue_long && (sb.issue_rd != 5'd0)) begin
            set_mask_s[sb.issue_rd] = 1'b1;
        end else begin
            set_mask_s = 32'd0;
        end
        if (sb.wb_valid && (sb.wb_rd != 5'd0)) begin
            clr_mask_s[sb.wb_rd] = 1'b1;
        end else begin
            clr_mask_s = 32'd0;
        end
    end

    // Clear first, then set, so a new issue wins over a retiring write.
    assign busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & REG0_MASK;

    // Saturating stall counter next value.
    always_comb begin
        stall_count_next_s = stall_count_r;
        if (stall_s && (stall_count_r != COUNT_MAX)) begin
            stall_count_next_s = stall_count_r + 32'd1;
        end else begin
            stall_count_next_s = stall_count_r;
        end
    end

    // Busy array and stall counter state; reset discards all pending writes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_r        <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            busy_r        <= busy_next_s;
            stall_count_r <= stall_count_next_s;
        end
    end

    // During reset the hazard output is forced low along with the state.
    assign sb.stall       = stall_s & nRST;
    assign sb.busy_vec    = busy_r;
    assign sb.stall_count = stall_count_r;

endmodule : scoreboard_unit

// File: tb/tb_scoreboard_unit.sv
// Self-checking bench for scoreboard_unit: directed hazard scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_scoreboard_unit;

    logic CLK;
    logic nRST;

    scoreboard_unit_if sb_if ();

    scoreboard_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .sb   (sb_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: one flag per register plus a plain counter.
    bit     m_busy [32];
    longint m_count;
    bit     preload_pending = 1'b0;
    longint preload_val     = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare DUT against the model, then advance the model.
    always @(negedge CLK) begin
        bit     eff [32];
        bit     exp_stall;
        logic [31:0] exp_vec;
        if (!nRST) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_count = 0;
            check("rst_stall", longint'(sb_if.stall), 0);
            check("rst_busy_vec", longint'(sb_if.busy_vec), 0);
            check("rst_stall_count", longint'(sb_if.stall_count), 0);
        end else begin
            if (preload_pending) begin
                m_count = preload_val;
                preload_pending = 1'b0;
            end
            for (int r = 0; r < 32; r++)
                eff[r] = m_busy[r] && !(sb_if.wb_valid && (int'(sb_if.wb_rd) == r));
            exp_stall = sb_if.issue_valid && !sb_if.flush &&
                        (eff[sb_if.id_rsel1] || eff[sb_if.id_rsel2] ||
                         (sb_if.issue_long && eff[sb_if.issue_rd]));
            exp_vec = 32'd0;
            for (int r = 0; r < 32; r++) exp_vec[r] = m_busy[r];
            check("stall", longint'(sb_if.stall), longint'(exp_stall));
            check("busy_vec", longint'(sb_if.busy_vec), longint'(exp_vec));
            check("stall_count", longint'(sb_if.stall_count), m_count);
            // advance model to the next edge
            if (sb_if.wb_valid && sb_if.wb_rd != 5'd0) m_busy[sb_if.wb_rd] = 1'b0;
            if (sb_if.issue_valid && !sb_if.flush && !exp_stall && sb_if.issue_long &&
                sb_if.issue_rd != 5'd0)
                m_busy[sb_if.issue_rd] = 1'b1;
            if (exp_stall && m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
        end
    end

    // Apply one cycle of inputs shortly after the rising edge; return 2 time units later.
    task automatic step(input bit iv, input bit il, input int rd, input bit fl,
                        input int r1, input int r2, input bit wv, input int wrd);
        @(posedge CLK);
        #1;
        sb_if.issue_valid = iv;
        sb_if.issue_long  = il;
        sb_if.issue_rd    = 5'(rd);
        sb_if.flush       = fl;
        sb_if.id_rsel1    = 5'(r1);
        sb_if.id_rsel2    = 5'(r2);
        sb_if.wb_valid    = wv;
        sb_if.wb_rd       = 5'(wrd);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        nRST = 1'b0;
        sb_if.issue_valid = 1'b0;
        sb_if.issue_long  = 1'b0;
        sb_if.issue_rd    = 5'd0;
        sb_if.flush       = 1'b0;
        sb_if.id_rsel1    = 5'd0;
        sb_if.id_rsel2    = 5'd0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_rd       = 5'd0;
        repeat (3) @(posedge CLK);
        #2;
        check("lit_reset_busy", longint'(sb_if.busy_vec), 0);
        check("lit_reset_count", longint'(sb_if.stall_count), 0);
        nRST = 1'b1;

        // RAW on a pending long op; stall counted per stalled cycle
        step(1'b1, 1'b1, 5, 1'b0, 0, 0, 1'b0, 0);
        check("lit_set_not_yet", longint'(sb_if.busy_vec), 0);
        step(1'b1, 1'b0, 0, 1'b0, 5, 0, 1'b0, 0);
        check("lit_raw_stall", longint'(sb_if.stall), 1);
        check("lit_raw_busy", longint'(sb_if.busy_vec), 32'h20);
        check("lit_raw_count0", longint'(sb_if.stall_count), 0);
        step(1'b1, 1'b0, 0, 1'b0, 5, 0, 1'b0, 0);
        check("lit_raw_count1", longint'(sb_if.stall_count), 1);
        // same-cycle writeback forwards: no stall, clear visible next cycle
        step(1'b1, 1'b0, 0, 1'b0, 0, 5, 1'b1, 5);
        check("lit_wb_fwd_stall", longint'(sb_if.stall), 0);
        check("lit_wb_fwd_busy", longint'(sb_if.busy_vec), 32'h20);
        check("lit_count2", longint'(sb_if.stall_count), 2);
        idle();
        check("lit_wb_cleared", longint'(sb_if.busy_vec), 0);

        // set wins over a same-register writeback
        step(1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b1, 7);
        check("lit_waw_fwd_stall", longint'(sb_if.stall), 0);
        check("lit_waw_busy7", longint'(sb_if.busy_vec), 32'h80);
        idle();
        check("lit_set_wins", longint'(sb_if.busy_vec), 32'h80);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 7);
        idle();
        check("lit_busy7_clear", longint'(sb_if.busy_vec), 0);

        // register 0 is never busy
        step(1'b1, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0);
        check("lit_r0_stall", longint'(sb_if.stall), 0);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
        check("lit_r0_busy", longint'(sb_if.busy_vec), 0);
        check("lit_r0_stall2", longint'(sb_if.stall), 0);

        // flushed issue changes nothing
        step(1'b1, 1'b1, 9, 1'b1, 0, 0, 1'b0, 0);
        idle();
        check("lit_flush_busy", longint'(sb_if.busy_vec), 0);

        // asynchronous reset with a pending write
        step(1'b1, 1'b1, 3, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 3, 0, 1'b0, 0);
        check("lit_pre_rst_busy", longint'(sb_if.busy_vec), 32'h8);
        check("lit_pre_rst_stall", longint'(sb_if.stall), 1);
        nRST = 1'b0;
        #1;
        check("lit_rst_busy_now", longint'(sb_if.busy_vec), 0);
        check("lit_rst_count_now", longint'(sb_if.stall_count), 0);
        check("lit_rst_stall_now", longint'(sb_if.stall), 0);
        repeat (2) @(posedge CLK);
        #2;
        nRST = 1'b1;
        // stale writeback after reset is ignored
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 3);
        idle();
        check("lit_stale_wb", longint'(sb_if.busy_vec), 0);

        // saturation: preload near the top, then stall three cycles
        step(1'b1, 1'b1, 4, 1'b0, 0, 0, 1'b0, 0);
        force dut.stall_count_r = 32'hFFFF_FFFE;
        preload_val     = 64'hFFFF_FFFE;
        preload_pending = 1'b1;
        #1;
        release dut.stall_count_r;
        step(1'b1, 1'b0, 0, 1'b0, 4, 0, 1'b0, 0);
        check("lit_sat_start", longint'(sb_if.stall_count), 64'hFFFF_FFFE);
        step(1'b1, 1'b0, 0, 1'b0, 4, 0, 1'b0, 0);
        check("lit_sat_max", longint'(sb_if.stall_count), 64'hFFFF_FFFF);
        step(1'b1, 1'b0, 0, 1'b0, 4, 0, 1'b0, 0);
        check("lit_sat_hold1", longint'(sb_if.stall_count), 64'hFFFF_FFFF);
        idle();
        check("lit_sat_hold2", longint'(sb_if.stall_count), 64'hFFFF_FFFF);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 4);

        // randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                @(posedge CLK);
                #2;
                nRST = 1'b0;
                repeat (2) @(posedge CLK);
                #2;
                nRST = 1'b1;
            end
            step(($urandom_range(9, 0) < 8), $urandom_range(1, 0) == 1,
                 int'($urandom_range(7, 0)), ($urandom_range(9, 0) == 0),
                 int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                 ($urandom_range(9, 0) < 4), int'($urandom_range(7, 0)));
        end
        idle();
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_scoreboard_unit
